// File: rtl/irq_controller.sv
// Machine-level interrupt controller: masks and prioritises peripheral requests,
// raises the trap request with its mcause, tracks handler nesting and acknowledges on mret.
module irq_controller #(
  parameter int unsigned IRQ_NUM = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_i,
  input  logic               exception_i,
  input  logic               mret_i,
  input  logic [31:0]        mie_i,
  input  logic [IRQ_NUM-1:0] irq_req_i,
  output logic               irq_o,
  output logic [31:0]        irq_cause_o,
  output logic [IRQ_NUM-1:0] irq_ret_o
);

  typedef enum logic [1:0] {
    IDLE,
    IRQ,
    EXC,
    IRQ_EXC
  } state_t;

  state_t             state_q;
  logic [3:0]         idx_q;
  logic [31:0]        cause_q;
  logic [IRQ_NUM-1:0] pend;
  logic [3:0]         idx_w;
  logic [31:0]        cause_w;
  logic               take;
  logic               ack;
  logic [IRQ_NUM-1:0] ret_hot;
  logic               unused_mie;

  assign unused_mie = &{1'b0, mie_i};
  assign pend       = irq_req_i & mie_i[16 +: IRQ_NUM];

  // Scan from the top so the lowest pending line is the last one written.
  always_comb begin
    idx_w = '0;
    for (int unsigned i = 0; i < IRQ_NUM; i++) begin
      if (pend[IRQ_NUM-1-i]) idx_w = 4'(IRQ_NUM-1-i);
    end
  end

  assign cause_w = {1'b1, 26'b0, 1'b1, idx_w};

  always_comb begin
    ret_hot = '0;
    for (int unsigned i = 0; i < IRQ_NUM; i++) begin
      ret_hot[i] = (idx_q == 4'(i));
    end
  end

  // Outputs are gated by rst_i so an asserted reset silences them before any clock edge.
  assign take        = !rst_i && !stall_i && !exception_i && (state_q == IDLE) && (pend != '0);
  assign ack         = !rst_i && !stall_i && !exception_i && mret_i && (state_q == IRQ);
  assign irq_o       = take;
  assign irq_cause_o = take ? cause_w : cause_q;
  assign irq_ret_o   = ack ? ret_hot : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cause_q <= '0;
    end else if (!stall_i) begin
      case (state_q)
        IDLE: begin
          if (exception_i) begin
            state_q <= EXC;
          end else if (pend != '0) begin
            state_q <= IRQ;
            idx_q   <= idx_w;
            cause_q <= cause_w;
          end
        end
        IRQ: begin
          if (exception_i)  state_q <= IRQ_EXC;
          else if (mret_i)  state_q <= IDLE;
        end
        // A faulting mret does not retire, so an exception keeps the handler level.
        EXC: begin
          if (!exception_i && mret_i) state_q <= IDLE;
        end
        IRQ_EXC: begin
          if (!exception_i && mret_i) state_q <= IRQ;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
